rv32_mem_arbiter: RTL and testbench

- Shares one single-ported memory between the core's instruction fetch port (M0) and data port (M1).
- Sits between rv32_core and the unified memory model/controller.
- Arbitrates, latches the winning request, holds it stable on the memory port until completion, then routes completion and read data back to the owner.
- Data port has priority; an anti-starvation counter guarantees fetch progress.

---
 rtl/rv32_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_rv32_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: shares one single-ported memory between the fetch port
// (M0, i_*) and the data port (M1, d_*). The winning request is latched onto
// the m_* port and held until m_done; completion and read data are routed
// back to the owner. The data port has priority, and a wait counter lets a
// starved fetch win once it has lost MAX_WAIT arbitrations in a row.
//
// Optional build macro RV32_MEM_ARB_STATS_EN adds the grant/conflict counters
// stat_i_grants, stat_d_grants and stat_conflicts.
//
// state  | meaning
// IDLE   | no transfer in flight, m_valid=0, arbitrate every cycle
// BUSY_I | fetch request on the memory port, waiting for m_done
// BUSY_D | data request on the memory port, waiting for m_done

module rv32_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [31:0]       i_rdata,
    input  logic              d_valid,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic              m_valid,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic              m_done,
    input  logic [31:0]       m_rdata
`ifdef RV32_MEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_i_grants,
    output logic [31:0]       stat_d_grants,
    output logic [31:0]       stat_conflicts
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t            state_q, state_d;
    logic              m_valid_q, m_valid_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [31:0]       m_wdata_q, m_wdata_d;
    logic [3:0]        m_wstrb_q, m_wstrb_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;

    logic arb_en;
    logic i_cand;
    logic d_cand;
    logic grant_i;
    logic grant_d;

    // Arbitration, request latching and anti-starvation bookkeeping.
    always_comb begin
        state_d    = state_q;
        m_valid_d  = m_valid_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_wstrb_d  = m_wstrb_q;
        wait_cnt_d = wait_cnt_q;

        // Arbitration happens in IDLE and at the completion edge of a busy
        // transfer; the completing master's valid is stale in that cycle.
        arb_en  = (state_q == IDLE) || m_done;
        i_cand  = i_valid && (state_q != BUSY_I);
        d_cand  = d_valid && (state_q != BUSY_D);
        grant_i = arb_en && i_cand && ((wait_cnt_q >= 4'(MAX_WAIT)) || !d_cand);
        grant_d = arb_en && d_cand && !grant_i;

        if (grant_i) begin
            state_d    = BUSY_I;
            m_valid_d  = 1'b1;
            m_we_d     = 1'b0;
            m_addr_d   = i_addr;
            m_wdata_d  = '0;
            m_wstrb_d  = 4'h0;
            wait_cnt_d = 4'h0;
        end else if (grant_d) begin
            state_d   = BUSY_D;
            m_valid_d = 1'b1;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_wstrb_d = d_we ? d_wstrb : 4'h0;
            if (i_cand && (wait_cnt_q != 4'hF)) begin
                wait_cnt_d = wait_cnt_q + 4'h1;
            end
        end else if (arb_en) begin
            state_d   = IDLE;
            m_valid_d = 1'b0;
        end
    end

    // State and memory-port registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            m_valid_q  <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_wstrb_q  <= 4'h0;
            wait_cnt_q <= 4'h0;
        end else begin
            state_q    <= state_d;
            m_valid_q  <= m_valid_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_wstrb_q  <= m_wstrb_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Completion routing: done pulses follow m_done only for the owner.
    always_comb begin
        i_done  = m_done && (state_q == BUSY_I);
        d_done  = m_done && (state_q == BUSY_D);
        i_rdata = m_rdata;
        d_rdata = m_rdata;
    end

    assign m_valid = m_valid_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wstrb = m_wstrb_q;

`ifdef RV32_MEM_ARB_STATS_EN
    logic [31:0] stat_i_q, stat_i_d;
    logic [31:0] stat_d_q, stat_d_d;
    logic [31:0] stat_c_q, stat_c_d;

    // Grant and conflict counters; they wrap naturally at 2^32.
    always_comb begin
        stat_i_d = stat_i_q + {31'b0, grant_i};
        stat_d_d = stat_d_q + {31'b0, grant_d};
        stat_c_d = stat_c_q + {31'b0, (arb_en && i_cand && d_cand)};
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_i_q <= '0;
            stat_d_q <= '0;
            stat_c_q <= '0;
        end else begin
            stat_i_q <= stat_i_d;
            stat_d_q <= stat_d_d;
            stat_c_q <= stat_c_d;
        end
    end

    assign stat_i_grants  = stat_i_q;
    assign stat_d_grants  = stat_d_q;
    assign stat_conflicts = stat_c_q;
`endif

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed bench for rv32_mem_arbiter: a table of single transfers plus
// hand-written sequences for conflicts, back-to-back grants, starvation,
// stale-valid exclusion and asynchronous reset.

module tb_rv32_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_valid;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        m_valid;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_done;
    logic [31:0] m_rdata;
`ifdef RV32_MEM_ARB_STATS_EN
    logic [31:0] stat_i_grants;
    logic [31:0] stat_d_grants;
    logic [31:0] stat_conflicts;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv32_mem_arbiter #(.ADDR_W(32), .MAX_WAIT(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_valid),
        .i_addr  (i_addr),
        .i_done  (i_done),
        .i_rdata (i_rdata),
        .d_valid (d_valid),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_wstrb (d_wstrb),
        .d_done  (d_done),
        .d_rdata (d_rdata),
        .m_valid (m_valid),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_done  (m_done),
        .m_rdata (m_rdata)
`ifdef RV32_MEM_ARB_STATS_EN
        ,
        .stat_i_grants  (stat_i_grants),
        .stat_d_grants  (stat_d_grants),
        .stat_conflicts (stat_conflicts)
`endif
    );

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
        logic [31:0] rdata;
        logic        exp_we;
        logic [3:0]  exp_wstrb;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs [NV];

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Solo lat-1 transfer from IDLE, used to build up traffic counts.
    task automatic solo(input logic is_d, input logic [31:0] addr);
        if (is_d) begin
            d_valid = 1'b1; d_we = 1'b0; d_addr = addr;
        end else begin
            i_valid = 1'b1; i_addr = addr;
        end
        step();
        m_done = 1'b1; m_rdata = addr;
        #1;
        step();
        m_done = 1'b0; i_valid = 1'b0; d_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         4'h0, 2, 32'h0000_0013, 1'b0, 4'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0,         4'hF, 1, 32'hCAFE_F00D, 1'b0, 4'h0};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0208, 32'h1234_5678, 4'h3, 3, 32'h0000_0000, 1'b1, 4'h3};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 1, 32'hA5A5_A5A5, 1'b0, 4'h0};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0000, 32'h8000_0001, 4'h8, 1, 32'h7777_7777, 1'b1, 4'h8};

        reset = 1'b1;
        i_valid = 1'b0; i_addr = '0;
        d_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        m_done = 1'b0; m_rdata = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_m_valid", {31'b0, m_valid}, 32'h0);
        chk("rst_m_we",    {31'b0, m_we}, 32'h0);
        chk("rst_m_addr",  m_addr, 32'h0);
        chk("rst_m_wdata", m_wdata, 32'h0);
        chk("rst_m_wstrb", {28'b0, m_wstrb}, 32'h0);
        reset = 1'b0;
        step();

        // m_done while IDLE is ignored
        m_done = 1'b1; m_rdata = 32'h0000_0055;
        #1;
        chk("idle_i_done", {31'b0, i_done}, 32'h0);
        chk("idle_d_done", {31'b0, d_done}, 32'h0);
        chk("idle_i_rdata", i_rdata, 32'h0000_0055);
        step();
        m_done = 1'b0;
        chk("idle_m_valid", {31'b0, m_valid}, 32'h0);

        // table of single transfers
        for (int k = 0; k < NV; k++) begin
            v = vecs[k];
            if (v.is_d) begin
                d_valid = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wstrb = v.wstrb;
                i_addr = 32'h0000_BAD0;
            end else begin
                i_valid = 1'b1; i_addr = v.addr;
                d_we = 1'b1; d_wstrb = 4'hF; d_addr = 32'h0000_BAD4; d_wdata = 32'hFFFF_FFFF;
            end
            #1;
            chk($sformatf("v%0d_pre_m_valid", k), {31'b0, m_valid}, 32'h0);
            step();
            chk($sformatf("v%0d_m_valid", k), {31'b0, m_valid}, 32'h1);
            chk($sformatf("v%0d_m_addr", k), m_addr, v.addr);
            chk($sformatf("v%0d_m_we", k), {31'b0, m_we}, {31'b0, v.exp_we});
            chk($sformatf("v%0d_m_wstrb", k), {28'b0, m_wstrb}, {28'b0, v.exp_wstrb});
            if (v.is_d)
                chk($sformatf("v%0d_m_wdata", k), m_wdata, v.wdata);
            i_addr = 32'h1111_0000; d_addr = 32'h2222_0000; d_we = ~v.we;
            for (int w = 1; w < v.lat; w++) begin
                step();
                chk($sformatf("v%0d_wait_done", k), {30'b0, i_done, d_done}, 32'h0);
            end
            m_done = 1'b1; m_rdata = v.rdata;
            #1;
            chk($sformatf("v%0d_i_done", k), {31'b0, i_done}, {31'b0, !v.is_d});
            chk($sformatf("v%0d_d_done", k), {31'b0, d_done}, {31'b0, v.is_d});
            chk($sformatf("v%0d_rdata", k), v.is_d ? d_rdata : i_rdata, v.rdata);
            chk($sformatf("v%0d_hold_addr", k), m_addr, v.addr);
            chk($sformatf("v%0d_hold_we", k), {31'b0, m_we}, {31'b0, v.exp_we});
            step();
            m_done = 1'b0; m_rdata = '0; i_valid = 1'b0; d_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_after_m_valid", k), {31'b0, m_valid}, 32'h0);
        end

        // simultaneous requests: data first, fetch back-to-back
        step();
        i_valid = 1'b1; i_addr = 32'h0000_0300;
        d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0200; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        step();
        chk("both_m_addr", m_addr, 32'h0000_0200);
        chk("both_m_we", {31'b0, m_we}, 32'h1);
        chk("both_m_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("both_m_wstrb", {28'b0, m_wstrb}, 32'hF);
        m_done = 1'b1; m_rdata = 32'h0;
        #1;
        chk("both_d_done", {30'b0, i_done, d_done}, 32'h1);
        step();
        m_done = 1'b0; d_valid = 1'b0;
        chk("b2b_m_valid", {31'b0, m_valid}, 32'h1);
        chk("b2b_m_addr", m_addr, 32'h0000_0300);
        chk("b2b_m_we", {31'b0, m_we}, 32'h0);
        chk("b2b_m_wstrb", {28'b0, m_wstrb}, 32'h0);
        m_done = 1'b1; m_rdata = 32'h0BAD_F00D;
        #1;
        chk("b2b_i_done", {30'b0, i_done, d_done}, 32'h2);
        chk("b2b_i_rdata", i_rdata, 32'h0BAD_F00D);
        step();
        m_done = 1'b0; i_valid = 1'b0;
        chk("b2b_idle", {31'b0, m_valid}, 32'h0);

        // owner keeps valid through m_done: stale, so an idle cycle first
        i_valid = 1'b1; i_addr = 32'h0000_0400;
        step();
        chk("stale_m_addr", m_addr, 32'h0000_0400);
        m_done = 1'b1;
        #1;
        step();
        m_done = 1'b0; i_addr = 32'h0000_0404;
        chk("stale_gap", {31'b0, m_valid}, 32'h0);
        step();
        chk("stale_regrant", {31'b0, m_valid}, 32'h1);
        chk("stale_regrant_addr", m_addr, 32'h0000_0404);
        m_done = 1'b1;
        #1;
        chk("stale_i_done", {31'b0, i_done}, 32'h1);
        i_valid = 1'b0;
        step();
        m_done = 1'b0;

        // anti-starvation with MAX_WAIT=2: M1, M1, M0, then counter cleared
        d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0600;
        i_valid = 1'b1; i_addr = 32'h0000_0500;
        step();
        chk("mw_r1", m_addr, 32'h0000_0600);
        m_done = 1'b1; #1; i_valid = 1'b0;
        step();
        m_done = 1'b0;
        chk("mw_idle1", {31'b0, m_valid}, 32'h0);
        i_valid = 1'b1;
        step();
        chk("mw_r2", m_addr, 32'h0000_0600);
        m_done = 1'b1; #1; i_valid = 1'b0;
        step();
        m_done = 1'b0;
        chk("mw_idle2", {31'b0, m_valid}, 32'h0);
        i_valid = 1'b1;
        step();
        chk("mw_r3", m_addr, 32'h0000_0500);
        m_done = 1'b1; #1;
        chk("mw_r3_done", {30'b0, i_done, d_done}, 32'h2);
        i_valid = 1'b0; d_valid = 1'b0;
        step();
        m_done = 1'b0;
        chk("mw_idle3", {31'b0, m_valid}, 32'h0);
        i_valid = 1'b1; d_valid = 1'b1;
        step();
        chk("mw_r4", m_addr, 32'h0000_0600);
        m_done = 1'b1; #1;
        step();
        m_done = 1'b0; d_valid = 1'b0;
        chk("mw_r5", m_addr, 32'h0000_0500);
        m_done = 1'b1; #1; i_valid = 1'b0;
        step();
        m_done = 1'b0;
        chk("mw_end", {31'b0, m_valid}, 32'h0);

        // asynchronous reset in the middle of a data transfer
        d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0700; d_wdata = 32'h1; d_wstrb = 4'h1;
        step();
        chk("ar_busy", {31'b0, m_valid}, 32'h1);
        d_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("ar_m_valid", {31'b0, m_valid}, 32'h0);
        chk("ar_m_addr", m_addr, 32'h0);
        chk("ar_m_wstrb", {28'b0, m_wstrb}, 32'h0);
        reset = 1'b0;
        step();
        m_done = 1'b1;
        #1;
        chk("ar_no_d_done", {31'b0, d_done}, 32'h0);
        step();
        m_done = 1'b0;
        solo(1'b0, 32'h0000_0A00);
        chk("ar_recover", {31'b0, m_valid}, 32'h0);

`ifdef RV32_MEM_ARB_STATS_EN
        reset = 1'b1;
        #1;
        chk("st_rst_i", stat_i_grants, 32'h0);
        chk("st_rst_c", stat_conflicts, 32'h0);
        reset = 1'b0;
        step();
        i_valid = 1'b1; i_addr = 32'h0000_0800;
        d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0900; d_wstrb = 4'hF;
        step();
        m_done = 1'b1; #1;
        step();
        m_done = 1'b0; d_valid = 1'b0;
        m_done = 1'b1; #1;
        step();
        m_done = 1'b0; i_valid = 1'b0;
        solo(1'b0, 32'h0000_0804);
        solo(1'b0, 32'h0000_0808);
        solo(1'b1, 32'h0000_0904);
        chk("st_i_grants", stat_i_grants, 32'd3);
        chk("st_d_grants", stat_d_grants, 32'd2);
        chk("st_conflicts", stat_conflicts, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
